// File: rtl/updown_sweep_ctrl_if.sv
// System-side handshake for the up/down sweep sequencer: start request,
// bounds and repeat count in; busy/done/err status and sweep progress out.
interface updown_sweep_ctrl_if;
  logic       start;
  logic       abort;
  logic       use_def;
  logic [3:0] lo;
  logic [3:0] hi;
  logic [3:0] sweeps;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] sweep_idx;

  modport master (
    output start, abort, use_def, lo, hi, sweeps,
    input  busy, done, err, sweep_idx
  );

  modport slave (
    input  start, abort, use_def, lo, hi, sweeps,
    output busy, done, err, sweep_idx
  );
endinterface

// File: rtl/updown_sweep_ctrl.sv
// Drives the direction input of a free-running 4-bit up/down counter from its
// own output so it sweeps lo..hi..lo a programmed number of times.
//   IDLE | counter free-runs up, waiting for start
//   SEEK | count down (wrapping) until cnt == lo
//   UP   | count up until cnt == hi
//   DOWN | count down until cnt == lo, one sweep completed there
//   DONE | one-cycle completion pulse, then back to IDLE
module updown_sweep_ctrl #(
  parameter logic [3:0] LO_DEF = 4'd0,
  parameter logic [3:0] HI_DEF = 4'd15
) (
  input  logic               clk,
  input  logic               rst_n,
  updown_sweep_ctrl_if.slave bus,
  input  logic [3:0]         cnt,
  output logic               ctrl
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SEEK = 3'd1;
  localparam logic [2:0] ST_UP   = 3'd2;
  localparam logic [2:0] ST_DOWN = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0] state_q, state_d;
  logic [3:0] lo_q, lo_d;
  logic [3:0] hi_q, hi_d;
  logic [3:0] n_q, n_d;
  logic [3:0] idx_q, idx_d;
  logic       err_q, err_d;

  logic [3:0] lo_sel;
  logic [3:0] hi_sel;

  assign lo_sel = bus.use_def ? LO_DEF : bus.lo;
  assign hi_sel = bus.use_def ? HI_DEF : bus.hi;

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    n_d     = n_q;
    idx_d   = idx_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (lo_sel >= hi_sel) begin
            err_d = 1'b1;
          end else begin
            lo_d    = lo_sel;
            hi_d    = hi_sel;
            n_d     = bus.sweeps;
            idx_d   = 4'd0;
            state_d = ST_SEEK;
          end
        end
      end
      ST_SEEK: begin
        if (cnt == lo_q) state_d = ST_UP;
      end
      ST_UP: begin
        if (cnt == hi_q) state_d = ST_DOWN;
      end
      ST_DOWN: begin
        if (cnt == lo_q) begin
          idx_d = idx_q + 4'd1;
          // n_q == 0 is continuous mode: never terminate, let the index wrap
          if ((n_q != 4'd0) && ((idx_q + 4'd1) == n_q)) state_d = ST_DONE;
          else                                            state_d = ST_UP;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // abort overrides any bound or completion transition and freezes the index
    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      idx_d   = idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lo_q    <= 4'd0;
      hi_q    <= 4'd0;
      n_q     <= 4'd0;
      idx_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Direction turns on the same edge the bound appears, so there is no overshoot.
  always_comb begin
    case (state_q)
      ST_SEEK: ctrl = (cnt == lo_q);
      ST_UP:   ctrl = (cnt != hi_q);
      ST_DOWN: ctrl = (cnt == lo_q);
      default: ctrl = 1'b1;
    endcase
  end

  assign bus.busy      = (state_q == ST_SEEK) || (state_q == ST_UP) || (state_q == ST_DOWN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.err       = err_q;
  assign bus.sweep_idx = idx_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Closed-loop bench: a behavioural counter is driven by the sequencer, and a
// trajectory model predicts cnt/ctrl/status for every cycle of every run.
module tb_updown_sweep_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cnt_rst_n = 1'b0;
  logic [3:0] cnt;
  logic       ctrl;

  updown_sweep_ctrl_if bus();

  updown_sweep_ctrl #(.LO_DEF(4'd0), .HI_DEF(4'd15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .cnt   (cnt),
    .ctrl  (ctrl)
  );

  always #5 clk = ~clk;

  // The counter being sequenced; it has its own reset.
  always @(posedge clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n) cnt <= 4'd0;
    else            cnt <= ctrl ? cnt + 4'd1 : cnt - 4'd1;
  end

  typedef struct {
    int cnt;
    bit ctrl;
    bit busy;
    bit done;
    bit err;
    int idx;
  } rec_t;

  rec_t q[$];
  rec_t m_last = '{cnt: 0, ctrl: 1'b1, busy: 1'b0, done: 1'b0, err: 1'b0, idx: 0};
  int   trace[$];
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare: scheduled run records first, otherwise idle free-run.
  always @(negedge clk) begin : cmp
    rec_t r;
    if (chk_en) begin
      if (q.size() > 0) begin
        r = q.pop_front();
      end else begin
        r.cnt  = m_last.ctrl ? (m_last.cnt + 1) % 16 : (m_last.cnt + 15) % 16;
        r.ctrl = 1'b1;
        r.busy = 1'b0;
        r.done = 1'b0;
        r.err  = 1'b0;
        r.idx  = rst_n ? m_last.idx : 0;
      end
      chk("cnt",       int'(cnt),           r.cnt);
      chk("ctrl",      int'(ctrl),          int'(r.ctrl));
      chk("busy",      int'(bus.busy),      int'(r.busy));
      chk("done",      int'(bus.done),      int'(r.done));
      chk("err",       int'(bus.err),       int'(r.err));
      chk("sweep_idx", int'(bus.sweep_idx), r.idx);
      m_last = r;
    end
  end

  // Whole trajectory of an accepted run: seek down to lo, then lo->hi->lo sweeps.
  task automatic push_run(input int c0, input int lo, input int hi, input int n,
                          output int len);
    int   cs[$];
    int   ix[$];
    int   c;
    int   s;
    int   last;
    rec_t r;
    c = c0;
    forever begin
      cs.push_back(c); ix.push_back(0);
      if (c == lo) break;
      c = (c + 15) % 16;
    end
    s = 0;
    forever begin
      for (int v = lo + 1; v <= hi; v++) begin cs.push_back(v); ix.push_back(s % 16); end
      for (int v = hi - 1; v >= lo; v--) begin cs.push_back(v); ix.push_back(s % 16); end
      s++;
      if (n != 0 && s == n) break;
      if (n == 0 && cs.size() >= 41) break;
    end
    last = cs.size() - 1;
    for (int i = 0; i < last; i++) begin
      r.cnt  = cs[i];
      r.ctrl = (cs[i+1] == (cs[i] + 1) % 16);
      r.busy = 1'b1; r.done = 1'b0; r.err = 1'b0;
      r.idx  = ix[i];
      q.push_back(r);
    end
    if (n != 0) begin
      r.cnt = cs[last]; r.ctrl = 1'b1; r.busy = 1'b1; r.done = 1'b0; r.err = 1'b0;
      r.idx = ix[last];
      q.push_back(r);
      r.cnt = (lo + 1) % 16; r.ctrl = 1'b1; r.busy = 1'b0; r.done = 1'b1; r.err = 1'b0;
      r.idx = n % 16;
      q.push_back(r);
    end
    len = q.size();
  endtask

  // abort_j: -1 none, -2 random, else record index at which abort is driven.
  task automatic run(input int lo_i, input int hi_i, input int n_i, input int ud,
                     input int want_c0, input int abort_j, input bit sid, input bit junk,
                     output int nbusy, output int ndone, output int nerr,
                     output int x_busy, output int x_done, output int x_ctrl, output int x_idx);
    int   l, h, len, j, c0, guard;
    rec_t r;
    nbusy = 0; ndone = 0; nerr = 0;
    x_busy = -1; x_done = -1; x_ctrl = -1; x_idx = -1;
    trace.delete();
    guard = 0;
    c0 = 0;
    forever begin
      @(negedge clk); #1;
      bus.abort = 1'b0;
      if (q.size() == 0 && !m_last.busy && !m_last.done) begin
        c0 = (m_last.cnt + 1) % 16;
        if (want_c0 < 0 || c0 == want_c0) break;
        if (junk && ($urandom % 4 == 0)) bus.abort = 1'b1;
      end
      guard++;
      if (guard > 300) begin chk("wait_idle_timeout", 0, 1); return; end
    end
    l = ud ? 0 : lo_i;
    h = ud ? 15 : hi_i;
    bus.start   = 1'b1;
    bus.use_def = ud[0];
    bus.lo      = 4'(lo_i);
    bus.hi      = 4'(hi_i);
    bus.sweeps  = 4'(n_i);
    if (l >= h) begin
      r.cnt = c0; r.ctrl = 1'b1; r.busy = 1'b0; r.done = 1'b0; r.err = 1'b1;
      r.idx = m_last.idx;
      q.push_back(r);
      len = 1;
      j = -1;
    end else begin
      push_run(c0, l, h, n_i, len);
      j = abort_j;
      if (abort_j == -2)
        j = (n_i == 0 || ($urandom % 4 == 0)) ? int'($urandom_range(0, len - 2)) : -1;
    end
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk); #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      trace.push_back(int'(cnt));
      nbusy += int'(bus.busy);
      ndone += int'(bus.done);
      nerr  += int'(bus.err);
      if (q.size() == 0 && !m_last.busy && !m_last.done) begin
        x_busy = int'(bus.busy); x_done = int'(bus.done);
        x_ctrl = int'(ctrl);     x_idx  = int'(bus.sweep_idx);
        return;
      end
      if (k == j) begin
        bus.abort = 1'b1;
        q.delete();
      end else if (sid && m_last.done) begin
        bus.start = 1'b1; bus.use_def = 1'b0;
        bus.lo = 4'd2; bus.hi = 4'd5; bus.sweeps = 4'd1;
      end else if (junk && ($urandom % 8 == 0)) begin
        bus.start = 1'b1;
      end
      if (junk) begin
        bus.lo = 4'($urandom); bus.hi = 4'($urandom);
        bus.sweeps = 4'($urandom); bus.use_def = 1'($urandom);
      end
    end
    chk("run_timeout", 0, 1);
  endtask

  int nb, nd, ne, xb, xd, xc, xi;
  int exp_single[13] = '{7, 6, 5, 4, 3, 2, 3, 4, 5, 4, 3, 2, 3};
  int exp_min[6]     = '{14, 15, 14, 15, 14, 15};
  int exp_cont[4]    = '{4, 5, 6, 5};

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.use_def = 1'b0;
    bus.lo = 4'd0; bus.hi = 4'd0; bus.sweeps = 4'd0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err",  int'(bus.err), 0);
    chk("rst_idx",  int'(bus.sweep_idx), 0);
    chk("rst_ctrl", int'(ctrl), 1);
    rst_n = 1'b1; cnt_rst_n = 1'b1; chk_en = 1'b1;

    // single sweep starting from cnt = 7
    run(2, 5, 1, 0, 7, -1, 1'b0, 1'b0, nb, nd, ne, xb, xd, xc, xi);
    chk("single_len", int'(trace.size() >= 13), 1);
    if (trace.size() >= 13)
      for (int i = 0; i < 13; i++) chk("single_cnt", trace[i], exp_single[i]);
    chk("single_busy_cycles", nb, 12);
    chk("single_done_pulses", nd, 1);
    chk("single_idx", xi, 1);

    // reset asserted while in UP with cnt == hi (ctrl would be 0)
    run(0, 0, 0, 0, -1, -1, 1'b0, 1'b0, nb, nd, ne, xb, xd, xc, xi);
    begin : reset_mid
      int lenr;
      int c0w;
      c0w = 0;
      while (c0w < 300 && ((m_last.cnt + 1) % 16) != 7) begin @(negedge clk); #1; c0w++; end
      bus.start = 1'b1; bus.use_def = 1'b0; bus.lo = 4'd2; bus.hi = 4'd5; bus.sweeps = 4'd1;
      push_run(7, 2, 5, 1, lenr);
      repeat (8) begin @(negedge clk); #1; bus.start = 1'b0; end
      @(posedge clk); #1;
      rst_n = 1'b0;
      q.delete();
      #1;
      chk("midrst_busy", int'(bus.busy), 0);
      chk("midrst_done", int'(bus.done), 0);
      chk("midrst_ctrl", int'(ctrl), 1);
      chk("midrst_idx",  int'(bus.sweep_idx), 0);
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
    end

    // rejected start: lo == hi
    run(9, 9, 1, 0, -1, -1, 1'b0, 1'b0, nb, nd, ne, xb, xd, xc, xi);
    chk("bad_err_pulses", ne, 1);
    chk("bad_busy_cycles", nb, 0);
    chk("bad_busy_after", xb, 0);

    // default bounds, three sweeps, starting with cnt already at 0
    run(5, 3, 3, 1, 0, -1, 1'b0, 1'b0, nb, nd, ne, xb, xd, xc, xi);
    chk("def_busy_cycles", nb, 91);
    chk("def_done_pulses", nd, 1);
    chk("def_idx", xi, 3);

    // continuous mode, abort in DOWN with cnt == 5
    run(4, 6, 0, 0, 4, 3, 1'b0, 1'b0, nb, nd, ne, xb, xd, xc, xi);
    chk("cont_len", int'(trace.size() >= 4), 1);
    if (trace.size() >= 4)
      for (int i = 0; i < 4; i++) chk("cont_cnt", trace[i], exp_cont[i]);
    chk("cont_done_pulses", nd, 0);
    chk("cont_busy_after", xb, 0);
    chk("cont_ctrl_after", xc, 1);
    chk("cont_idx", xi, 0);

    // minimum span, with a start driven during the DONE cycle
    run(14, 15, 2, 0, 14, -1, 1'b1, 1'b0, nb, nd, ne, xb, xd, xc, xi);
    chk("min_len", int'(trace.size() >= 6), 1);
    if (trace.size() >= 6)
      for (int i = 0; i < 6; i++) chk("min_cnt", trace[i], exp_min[i]);
    chk("min_done_pulses", nd, 1);
    chk("min_idx", xi, 2);
    chk("min_busy_after", xb, 0);

    for (int t = 0; t < 30; t++) begin
      int lo_r, hi_r, n_r, ud_r;
      ud_r = ($urandom % 4 == 0) ? 1 : 0;
      lo_r = $urandom % 16;
      hi_r = $urandom % 16;
      n_r  = ($urandom % 4 == 0) ? 0 : int'($urandom_range(1, 3));
      if (!ud_r && lo_r < hi_r && (hi_r - lo_r) <= 2 && ($urandom % 2 == 0))
        n_r = int'($urandom_range(8, 15));
      run(lo_r, hi_r, n_r, ud_r, -1, -2, 1'b0, 1'b1, nb, nd, ne, xb, xd, xc, xi);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/updown_sweep_ctrl.md
# updown_sweep_ctrl

Sequencer for the 4-bit up/down counter: it drives the counter's direction input `ctrl` from the counter's own `cnt` output, so the counter sweeps back and forth between two programmed bounds. The sweep repeats a programmed number of times, or runs indefinitely. The block sits beside the counter on the same clock. It owns the counter's `ctrl` input and has a start/busy/done handshake toward the system.

## Interface
- `LO_DEF`, 4'd0, lower bound used when `use_def` is high at start.
- `HI_DEF`, 4'd15, upper bound used when `use_def` is high at start.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request; honoured only in IDLE.
- `abort`  in  1  stop the sweep; wins over every other event.
- `use_def`  in  1  at start: 1 uses `LO_DEF`/`HI_DEF`, 0 uses the `lo`/`hi` ports.
- `lo`  in  4  lower bound, sampled at start.
- `hi`  in  4  upper bound, sampled at start.
- `sweeps`  in  4  number of full lo→hi→lo sweeps, sampled at start; 0 means continuous.
- `cnt`  in  4  counter output (feedback).
- `ctrl`  out  1  counter direction: 1 = up, 0 = down.
- `busy`  out  1  high in SEEK, UP and DOWN.
- `done`  out  1  one-cycle pulse when the programmed sweeps complete.
- `err`  out  1  one-cycle pulse when a start is rejected.
- `sweep_idx`  out  4  number of completed sweeps in the current run.

## Operation
- States: IDLE, SEEK, UP, DOWN, DONE. Encoding is free.
- `ctrl` is combinational from the registered state, `cnt`, `lo_r` and `hi_r`. There is no combinational path from `start` or `abort` to `ctrl`.
- The counter always counts (no enable), so `ctrl` is valid in every cycle, including IDLE.
- **IDLE:** `ctrl`=1 (counter free-runs up and wraps).
  - On `start`, latch `lo_r`, `hi_r`, `n_r`.
  - If the selected lo ≥ hi: do not latch; pulse `err` for 1 cycle; stay in IDLE.
  - Otherwise clear `sweep_idx` and go to SEEK.
- **SEEK:** `ctrl` = (`cnt`==`lo_r`) ? 1 : 0.
  - When `cnt`==`lo_r`, go to UP.
  - The counter reaches lo in at most 15 cycles because it wraps downward.
- **UP:** `ctrl` = (`cnt`==`hi_r`) ? 0 : 1.
  - When `cnt`==`hi_r`, go to DOWN.
- **DOWN:** `ctrl` = (`cnt`==`lo_r`) ? 1 : 0.
  - When `cnt`==`lo_r`, increment `sweep_idx` (4-bit, wraps 15→0).
  - If `n_r`≠0 and `sweep_idx`+1==`n_r`, go to DONE; otherwise go to UP.
- **DONE:** `ctrl`=1; `done`=1 for this one cycle; next state is IDLE.
- **Abort:** `abort` in any non-IDLE state forces IDLE on the next edge. No `done` pulse is issued, and `sweep_idx` holds its value. `abort` in IDLE has no effect.
- `start` outside IDLE is ignored.
- Changes to `lo`, `hi`, `sweeps` or `use_def` after start have no effect.
- In continuous mode (`n_r`=0), the block sweeps until abort. `sweep_idx` wraps.

## Timing
- **Reset values** (asynchronous on `rst_n` low): state IDLE, `ctrl`=1, `busy`=0, `done`=0, `err`=0, `sweep_idx`=0, `lo_r`=0, `hi_r`=0, `n_r`=0.
- **Reset mid-sweep:** the block is in IDLE immediately. The counter resets independently.
- **Start latency:** `busy` rises 1 cycle after the `start` edge.
- **Turnaround:** the direction reverses on the same edge at which the bound is seen on `cnt`, with no overshoot. The sequence at hi is …, hi-1, hi, hi-1, ….
- **Sweep period:** lo→lo takes 2·(hi−lo) cycles.
- **End of run:**
  - `done` is high in the cycle after the edge where the final `cnt`==`lo_r` was observed in DOWN.
  - In that final cycle `ctrl`=1, so the counter moves lo→lo+1 and then free-runs.
  - `busy` falls in the same cycle that `done` rises.
- **Boundary cases:**
  - hi−lo=1 gives the alternating sequence lo, hi, lo, hi.
  - lo=0, hi=15 never wraps while in UP or DOWN.
- **Simultaneous events:** `abort` has priority over the bound transitions and over DONE.
- **No back-to-back start:** `start` in the DONE cycle is ignored. The earliest new start is in the following IDLE cycle.

## Test plan
- **Reset mid-sweep:** reset, then start with lo=2, hi=5, sweeps=1; pull `rst_n` low in UP → outputs return to reset values immediately; after release the counter free-runs up.
- **Single sweep from cnt=7:** lo=2, hi=5, sweeps=1 → `cnt` goes 7,6,5,4,3,2,3,4,5,4,3,2,3; `done` pulses once at the end; `sweep_idx`=1; `busy` high for 12 cycles.
- **Bad bounds:** lo=9, hi=9, `use_def`=0 → `err` pulses 1 cycle; `busy` stays 0; state remains IDLE.
- **Default bounds, repeated sweeps:** `use_def`=1, sweeps=3 → counter sweeps 0..15 three times with no wrap; `done` fires after 3·30 cycles plus the SEEK cycles; `sweep_idx`=3.
- **Continuous mode and abort:** sweeps=0, lo=4, hi=6 → pattern 4,5,6,5,4 repeats; `abort` asserted in DOWN with `cnt`=5 → IDLE next edge, no `done`, `ctrl`=1.
- **Minimum span and ignored start:** lo=14, hi=15, sweeps=2 → `cnt` alternates 14,15,14,15,14; `done` pulses; a `start` asserted in the DONE cycle is ignored.
